// File: rtl/wb_arb_pkg.sv
// Shared encodings and Wishbone bus widths for the round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo N.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    // Scan farthest offset first so the nearest requester after `last` wins.
    for (int i = N; i >= 1; i--) begin
      int idx;
      idx = (int'(last) + i) % N;
      if (req[idx]) begin
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_idx     = IW'(idx);
        pick_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter, N masters onto one slave port.
// Optional STB-without-ACK timeout when WB_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | no owner; pick next requester round-robin (dead cycle between tenures)
// ST_OWNED | grant holds the bus until its CYC drops
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [N_MASTERS*WB_ADR_W-1:0] i_m_adr,
  input  logic [N_MASTERS*WB_DAT_W-1:0] i_m_dat,
  input  logic [N_MASTERS*WB_SEL_W-1:0] i_m_sel,
  input  logic [N_MASTERS-1:0]          i_m_we,
  input  logic [N_MASTERS-1:0]          i_m_cyc,
  input  logic [N_MASTERS-1:0]          i_m_stb,
  output logic [WB_DAT_W-1:0]           o_m_dat,
  output logic [N_MASTERS-1:0]          o_m_ack,
  output logic [N_MASTERS-1:0]          o_m_err,
  output logic [WB_ADR_W-1:0]           o_s_adr,
  output logic [WB_DAT_W-1:0]           o_s_dat,
  output logic [WB_SEL_W-1:0]           o_s_sel,
  output logic                          o_s_we,
  output logic                          o_s_cyc,
  output logic                          o_s_stb,
  input  logic [WB_DAT_W-1:0]           i_s_dat,
  input  logic                          i_s_ack
);

  localparam int IW = $clog2(N_MASTERS);

  arb_state_t           state;
  logic [IW-1:0]        grant;
  logic [N_MASTERS-1:0] grant_oh;
  logic [IW-1:0]        last;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  logic owned;
  logic cyc_g;
  logic stb_g;
  logic to_hit;

  wb_rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
    .req        (i_m_cyc),
    .last       (last),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign owned = (state == ST_OWNED);
  assign cyc_g = i_m_cyc[grant];
  assign stb_g = i_m_stb[grant];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_oh <= N_MASTERS'(1);
      last     <= IW'(N_MASTERS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant    <= pick_idx;
            grant_oh <= pick_oh;
            state    <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!cyc_g) begin
            last  <= grant;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign to_hit = owned && stb_g && !i_s_ack && (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      to_cnt <= '0;
    end else if (!owned || i_s_ack || to_hit) begin
      to_cnt <= '0;
    end else if (stb_g) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign o_s_adr = i_m_adr[grant*WB_ADR_W +: WB_ADR_W];
  assign o_s_dat = i_m_dat[grant*WB_DAT_W +: WB_DAT_W];
  assign o_s_sel = i_m_sel[grant*WB_SEL_W +: WB_SEL_W];
  assign o_s_we  = i_m_we[grant];
  assign o_s_cyc = owned && cyc_g && !to_hit;
  assign o_s_stb = owned && stb_g && !to_hit;

  assign o_m_dat = i_s_dat;
  assign o_m_ack = (owned && i_s_ack) ? grant_oh : '0;
  assign o_m_err = to_hit ? grant_oh : '0;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed-vector bench for wb_rr_arbiter with three masters and a 16-cycle timeout.
module tb_wb_rr_arbiter;

  localparam int N = 3;

  logic          i_clk;
  logic          i_reset_n;
  logic [N*32-1:0] m_adr;
  logic [N*32-1:0] m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_stb;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [31:0]     s_adr;
  logic [31:0]     s_dat_o;
  logic [3:0]      s_sel;
  logic            s_we;
  logic            s_cyc;
  logic            s_stb;
  logic [31:0]     s_dat;
  logic            s_ack;

  int vec_cnt = 0;
  int err_cnt = 0;

  wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_m_adr   (m_adr),
    .i_m_dat   (m_dat),
    .i_m_sel   (m_sel),
    .i_m_we    (m_we),
    .i_m_cyc   (m_cyc),
    .i_m_stb   (m_stb),
    .o_m_dat   (m_dat_o),
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_s_adr   (s_adr),
    .o_s_dat   (s_dat_o),
    .o_s_sel   (s_sel),
    .o_s_we    (s_we),
    .o_s_cyc   (s_cyc),
    .o_s_stb   (s_stb),
    .i_s_dat   (s_dat),
    .i_s_ack   (s_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  initial begin
    m_adr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    m_dat = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};
    m_sel = {4'h4, 4'h2, 4'h1};
    m_we  = 3'b101;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    s_dat = 32'hDEAD_BEEF;
    s_ack = 1'b1;
    i_reset_n = 1'b0;

    // Reset state, with requests and a stray ack present
    tick();
    tick();
    chk("rst_cyc", 32'(s_cyc), 32'd0);
    chk("rst_stb", 32'(s_stb), 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_adr", s_adr, 32'h0000_0100);
    chk("rdata_bcast", m_dat_o, 32'hDEAD_BEEF);
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    tick();
    i_reset_n = 1'b1;

    // T1: m0 writes 0x1 to 0x0
    m_adr[31:0] = 32'h0;
    m_dat[31:0] = 32'h1;
    m_sel[3:0]  = 4'hF;
    m_cyc = 3'b001;
    m_stb = 3'b001;
    #1;
    chk("t1_cyc_same", 32'(s_cyc), 32'd0);
    tick();
    chk("t1_cyc", 32'(s_cyc), 32'd1);
    chk("t1_stb", 32'(s_stb), 32'd1);
    chk("t1_adr", s_adr, 32'h0);
    chk("t1_dat", s_dat_o, 32'h1);
    chk("t1_sel", 32'(s_sel), 32'hF);
    chk("t1_we", 32'(s_we), 32'd1);
    chk("t1_noack", 32'(m_ack), 32'd0);
    s_ack = 1'b1;
    #1;
    chk("t1_ack", 32'(m_ack), 32'b001);
    tick();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    #1;
    chk("t1_drop_cyc", 32'(s_cyc), 32'd0);
    tick();
    s_ack = 1'b1;
    #1;
    chk("t1_late_ack", 32'(m_ack), 32'd0);
    s_ack = 1'b0;
    m_adr[31:0] = 32'h0000_0100;
    m_dat[31:0] = 32'hA1A1_0001;
    m_sel[3:0]  = 4'h1;

    // T2: m0 and m1 together after reset
    do_reset();
    m_cyc = 3'b011;
    m_stb = 3'b011;
    tick();
    chk("t2_first", s_adr, 32'h0000_0100);
    s_ack = 1'b1;
    #1;
    chk("t2_ack_m0", 32'(m_ack), 32'b001);
    s_ack = 1'b0;
    m_cyc = 3'b010;
    m_stb = 3'b010;
    tick();
    chk("t2_dead", 32'(s_cyc), 32'd0);
    tick();
    chk("t2_second", s_adr, 32'h0000_0200);
    chk("t2_cyc", 32'(s_cyc), 32'd1);
    s_ack = 1'b1;
    #1;
    chk("t2_ack_m1", 32'(m_ack), 32'b010);
    s_ack = 1'b0;

    // T3: m0 back-to-back with m1 pending alternates
    m_cyc = 3'b001;
    m_stb = 3'b001;
    tick();
    tick();
    chk("t3_a", s_adr, 32'h0000_0100);
    m_cyc = 3'b011;
    m_stb = 3'b011;
    s_ack = 1'b1;
    #1;
    chk("t3_ack_only_m0", 32'(m_ack), 32'b001);
    s_ack = 1'b0;
    m_cyc = 3'b010;
    m_stb = 3'b010;
    tick();
    m_cyc = 3'b011;
    m_stb = 3'b011;
    #1;
    chk("t3_dead", 32'(s_cyc), 32'd0);
    tick();
    chk("t3_b", s_adr, 32'h0000_0200);
    m_cyc = 3'b001;
    m_stb = 3'b001;
    tick();
    tick();
    chk("t3_c", s_adr, 32'h0000_0100);

    // T4: three transfers within one m0 tenure, m1 pending
    m_cyc = 3'b011;
    for (int i = 0; i < 3; i++) begin
      m_stb = 3'b011;
      s_ack = 1'b1;
      #1;
      chk("t4_ack", 32'(m_ack), 32'b001);
      tick();
      s_ack = 1'b0;
      m_stb = 3'b010;
      #1;
      chk("t4_hold_adr", s_adr, 32'h0000_0100);
      chk("t4_hold_cyc", 32'(s_cyc), 32'd1);
      tick();
    end

    // T5: reset mid-tenure of m1
    m_cyc = 3'b010;
    m_stb = 3'b010;
    tick();
    tick();
    chk("t5_owner", s_adr, 32'h0000_0200);
    i_reset_n = 1'b0;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    s_ack = 1'b1;
    tick();
    chk("t5_rst_cyc", 32'(s_cyc), 32'd0);
    chk("t5_rst_ack", 32'(m_ack), 32'd0);
    i_reset_n = 1'b1;
    s_ack = 1'b0;
    tick();
    chk("t5_after", s_adr, 32'h0000_0100);
    chk("t5_after_cyc", 32'(s_cyc), 32'd1);

    // T7: three-way rotation
    do_reset();
    m_cyc = 3'b110;
    m_stb = 3'b110;
    tick();
    chk("t7_m1", s_adr, 32'h0000_0200);
    m_cyc = 3'b101;
    m_stb = 3'b101;
    tick();
    tick();
    chk("t7_m2", s_adr, 32'h0000_0300);
    chk("t7_m2_we", 32'(s_we), 32'd1);
    chk("t7_m2_sel", 32'(s_sel), 32'h4);
    m_cyc = 3'b001;
    m_stb = 3'b001;
    tick();
    tick();
    chk("t7_m0", s_adr, 32'h0000_0100);

    // T6: stuck slave
    do_reset();
    m_cyc = 3'b001;
    m_stb = 3'b001;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      chk("t6_err", 32'(m_err), (k == 16) ? 32'b001 : 32'd0);
      chk("t6_stb", 32'(s_stb), (k == 16) ? 32'd0 : 32'd1);
      tick();
    end
`else
    begin
      int errs;
      errs = 0;
      repeat (1000) begin
        if (m_err !== '0) errs++;
        tick();
      end
      chk("t6_no_err", 32'(errs), 32'd0);
      chk("t6_stb_stuck", 32'(s_stb), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
